pc_sequencer: RTL and testbench

- Program-counter sequencer for the single-cycle datapath.
- Owns the word-addressed instruction-memory address. Decides per cycle whether the current instruction commits, and computes the next PC from the branchEnable, jumpEnable and isZero signals.
- Supports free-run, single-step, abort and halt, so benches and top level can drive programs without a free-running counter.
- Sits between instruction memory, control and the ALU. execEnable gates register-file and data-memory write enables.

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/STEP/HALT control, next-PC selection, and commit gating.
// Optional committed-instruction counter enabled by defining RETIRE_COUNT_EN.
module pc_sequencer #(
  parameter int          ADDR_WIDTH  = 5,
  parameter int          LAST_ADDR   = 31,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stepMode,
  input  logic                  stepReq,
  input  logic                  abort,
  input  logic [31:0]           instruction,
  input  logic                  jumpEnable,
  input  logic                  branchEnable,
  input  logic                  isZero,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  execEnable,
  output logic                  running,
  output logic                  halted,
  output logic [1:0]            haltCause,
  output logic [15:0]           retireCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

  localparam logic [1:0]            CAUSE_NONE  = 2'b00;
  localparam logic [1:0]            CAUSE_OPC   = 2'b01;
  localparam logic [1:0]            CAUSE_RANGE = 2'b10;
  localparam logic [1:0]            CAUSE_ABORT = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] LP_ONE      = 1;
  localparam logic [ADDR_WIDTH:0]   LP_ONE_W    = 1;
  localparam logic [ADDR_WIDTH:0]   LP_LAST     = (ADDR_WIDTH+1)'(LAST_ADDR);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_running;
  logic                  r_halted;
  logic [1:0]            r_cause;

  logic [ADDR_WIDTH-1:0] w_imm;
  logic                  w_halt_op;
  logic [ADDR_WIDTH:0]   w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_branch;
  logic [ADDR_WIDTH:0]   w_target;
  logic                  w_oor;
  logic                  w_unused;

  assign w_imm     = instruction[ADDR_WIDTH-1:0];
  assign w_halt_op = (instruction[31:26] == HALT_OPCODE);
  assign w_unused  = ^instruction[25:ADDR_WIDTH];

  // Target is one bit wider so a sequential step past LAST_ADDR is visible as out of range.
  assign w_pc_inc  = {1'b0, r_pc} + LP_ONE_W;
  assign w_branch  = r_pc + LP_ONE + w_imm;

  always_comb begin
    w_target = w_pc_inc;
    if (jumpEnable) begin
      w_target = {1'b0, w_imm};
    end else if (branchEnable && isZero) begin
      w_target = {1'b0, w_branch};
    end
  end

  assign w_oor = (w_target > LP_LAST);

  always_comb begin
    execEnable = 1'b0;
    case (r_state)
      S_RUN:   execEnable = ~abort & ~w_halt_op;
      S_STEP:  execEnable = stepReq & ~abort & ~w_halt_op;
      default: execEnable = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_cause   <= CAUSE_NONE;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc      <= '0;
            r_cause   <= CAUSE_NONE;
            r_state   <= stepMode ? S_STEP : S_RUN;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        S_RUN, S_STEP: begin
          if (abort) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
            r_cause   <= CAUSE_ABORT;
          end else if (w_halt_op && (r_state == S_RUN || stepReq)) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
            r_cause   <= CAUSE_OPC;
          end else if (execEnable) begin
            // The instruction still commits; only the PC update is suppressed.
            if (w_oor) begin
              r_state   <= S_HALT;
              r_running <= 1'b0;
              r_halted  <= 1'b1;
              r_cause   <= CAUSE_RANGE;
            end else begin
              r_pc    <= w_target[ADDR_WIDTH-1:0];
              r_state <= stepMode ? S_STEP : S_RUN;
            end
          end else if (!stepMode) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign running   = r_running;
  assign halted    = r_halted;
  assign haltCause = r_cause;

`ifdef RETIRE_COUNT_EN
  logic [15:0] r_retire;
  logic        w_start_ok;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_HALT);

  always_ff @(posedge CLK) begin
    if (reset || w_start_ok) begin
      r_retire <= '0;
    end else if (execEnable && (r_retire != 16'hFFFF)) begin
      r_retire <= r_retire + 16'd1;
    end
  end

  assign retireCount = r_retire;
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed program scenarios plus randomized control traffic.
module tb_pc_sequencer;

  localparam int AW      = 5;
  localparam int LAST    = 31;
  localparam int HALT_OP = 63;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic          CLK = 1'b0;
  logic          reset, start, stepMode, stepReq, abort;
  logic [31:0]   instruction;
  logic          jumpEnable, branchEnable, isZero;
  logic [AW-1:0] pc;
  logic          execEnable, running, halted;
  logic [1:0]    haltCause;
  logic [15:0]   retireCount;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start), .stepMode(stepMode), .stepReq(stepReq),
    .abort(abort), .instruction(instruction), .jumpEnable(jumpEnable),
    .branchEnable(branchEnable), .isZero(isZero), .pc(pc), .execEnable(execEnable),
    .running(running), .halted(halted), .haltCause(haltCause), .retireCount(retireCount)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_state, m_pc, m_cause, m_cnt;
  logic obs_exec, exp_exec;

  function automatic logic [31:0] op(input int opc, input int imm);
    logic [31:0] r;
    r        = '0;
    r[31:26] = opc[5:0];
    r[4:0]   = imm[4:0];
    return r;
  endfunction

  function automatic int exp_retire();
`ifdef RETIRE_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Applies one cycle of inputs, samples execEnable before the edge, and advances the reference model.
  task automatic drive(input logic rst, input logic st, input logic sm, input logic sr, input logic ab,
                       input logic [31:0] ins, input logic je, input logic be, input logic iz);
    int tgt;
    bit hop, act;
    @(negedge CLK);
    reset = rst; start = st; stepMode = sm; stepReq = sr; abort = ab;
    instruction = ins; jumpEnable = je; branchEnable = be; isZero = iz;
    #1;
    obs_exec = execEnable;
    hop = (ins[31:26] == 6'h3F);
    act = (m_state == M_RUN) || (m_state == M_STEP && sr);
    exp_exec = act && !ab && !hop;
    if (je)            tgt = ins[4:0];
    else if (be && iz) tgt = (m_pc + 1 + ins[4:0]) % (2 ** AW);
    else               tgt = m_pc + 1;
    if (rst) begin
      m_state = M_IDLE; m_pc = 0; m_cause = 0; m_cnt = 0;
    end else if (m_state == M_IDLE || m_state == M_HALT) begin
      if (st) begin
        m_pc = 0; m_cause = 0; m_cnt = 0;
        m_state = sm ? M_STEP : M_RUN;
      end
    end else if (ab) begin
      m_state = M_HALT; m_cause = 3;
    end else if (hop && act) begin
      m_state = M_HALT; m_cause = 1;
    end else if (exp_exec) begin
      if (m_cnt < 65535) m_cnt++;
      if (tgt > LAST) begin
        m_state = M_HALT; m_cause = 2;
      end else begin
        m_pc = tgt;
        m_state = sm ? M_STEP : M_RUN;
      end
    end else if (!sm) begin
      m_state = M_RUN;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    checks += 6;
    if (pc !== 5'd0)          begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    if (running !== 1'b0)     begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    if (halted !== 1'b0)      begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    if (haltCause !== 2'b00)  begin errors++; $display("FAIL reset_cause: got %b want 00", haltCause); end
    if (retireCount !== 16'd0) begin errors++; $display("FAIL reset_retire: got %0d want 0", retireCount); end
    if (execEnable !== 1'b0)  begin errors++; $display("FAIL reset_exec: got %b want 0", execEnable); end
  endtask

  task automatic test_free_run();
    int n_exec = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !halted; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (m_pc == 3) ? op(HALT_OP, 0) : op(0, 0), 1'b0, 1'b0, 1'b0);
      n_exec += int'(obs_exec);
      checks += 2;
      if (obs_exec !== exp_exec) begin errors++; $display("FAIL free_exec: got %b want %b", obs_exec, exp_exec); end
      if (pc !== m_pc[AW-1:0])   begin errors++; $display("FAIL free_pc: got %0d want %0d", pc, m_pc); end
    end
    checks += 5;
    if (n_exec != 3)          begin errors++; $display("FAIL free_commits: got %0d want 3", n_exec); end
    if (pc !== 5'd3)          begin errors++; $display("FAIL free_final_pc: got %0d want 3", pc); end
    if (halted !== 1'b1)      begin errors++; $display("FAIL free_halted: got %b want 1", halted); end
    if (haltCause !== 2'b01)  begin errors++; $display("FAIL free_cause: got %b want 01", haltCause); end
    if (retireCount !== 16'(exp_retire())) begin errors++; $display("FAIL free_retire: got %0d want %0d", retireCount, exp_retire()); end
  endtask

  task automatic test_branch_jump();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && m_pc != 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(2, 5), 1'b0, 1'b1, 1'b1);
    checks++;
    if (pc !== 5'd10) begin errors++; $display("FAIL branch_taken: got %0d want 10", pc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(3, 4), 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 5'd4) begin errors++; $display("FAIL jump_to_4: got %0d want 4", pc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(2, 5), 1'b0, 1'b1, 1'b0);
    checks++;
    if (pc !== 5'd5) begin errors++; $display("FAIL branch_not_taken: got %0d want 5", pc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(3, 2), 1'b1, 1'b1, 1'b1);
    checks += 2;
    if (pc !== 5'd2)      begin errors++; $display("FAIL jump_priority: got %0d want 2", pc); end
    if (running !== 1'b1) begin errors++; $display("FAIL branch_running: got %b want 1", running); end
  endtask

  task automatic test_step();
    int n_exec = 0;
    logic sr;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      sr = (c == 3 || c == 7);
      drive(1'b0, 1'b0, 1'b1, sr, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
      n_exec += int'(obs_exec);
      checks += 2;
      if (obs_exec !== sr)     begin errors++; $display("FAIL step_exec c%0d: got %b want %b", c, obs_exec, sr); end
      if (pc !== m_pc[AW-1:0]) begin errors++; $display("FAIL step_pc c%0d: got %0d want %0d", c, pc, m_pc); end
    end
    checks += 3;
    if (n_exec != 2)      begin errors++; $display("FAIL step_commits: got %0d want 2", n_exec); end
    if (pc !== 5'd2)      begin errors++; $display("FAIL step_final_pc: got %0d want 2", pc); end
    if (running !== 1'b1) begin errors++; $display("FAIL step_running: got %b want 1", running); end
  endtask

  task automatic test_out_of_range();
    int n_exec = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !halted; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
      n_exec += int'(obs_exec);
    end
    checks += 4;
    if (n_exec != 32)        begin errors++; $display("FAIL oor_commits: got %0d want 32", n_exec); end
    if (pc !== 5'd31)        begin errors++; $display("FAIL oor_pc: got %0d want 31", pc); end
    if (halted !== 1'b1)     begin errors++; $display("FAIL oor_halted: got %b want 1", halted); end
    if (haltCause !== 2'b10) begin errors++; $display("FAIL oor_cause: got %b want 10", haltCause); end
  endtask

  task automatic test_abort();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, op(2, 5), 1'b0, 1'b1, 1'b1);
    checks += 4;
    if (obs_exec !== 1'b0)   begin errors++; $display("FAIL abort_exec: got %b want 0", obs_exec); end
    if (pc !== 5'd3)         begin errors++; $display("FAIL abort_pc: got %0d want 3", pc); end
    if (haltCause !== 2'b11) begin errors++; $display("FAIL abort_cause: got %b want 11", haltCause); end
    if (halted !== 1'b1)     begin errors++; $display("FAIL abort_halted: got %b want 1", halted); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    checks += 4;
    if (pc !== 5'd0)         begin errors++; $display("FAIL restart_pc: got %0d want 0", pc); end
    if (running !== 1'b1)    begin errors++; $display("FAIL restart_running: got %b want 1", running); end
    if (haltCause !== 2'b00) begin errors++; $display("FAIL restart_cause: got %b want 00", haltCause); end
    if (halted !== 1'b0)     begin errors++; $display("FAIL restart_halted: got %b want 0", halted); end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 5'd7) begin errors++; $display("FAIL midrun_setup_pc: got %0d want 7", pc); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    checks += 5;
    if (pc !== 5'd0)           begin errors++; $display("FAIL midrun_pc: got %0d want 0", pc); end
    if (running !== 1'b0)      begin errors++; $display("FAIL midrun_running: got %b want 0", running); end
    if (halted !== 1'b0)       begin errors++; $display("FAIL midrun_halted: got %b want 0", halted); end
    if (haltCause !== 2'b00)   begin errors++; $display("FAIL midrun_cause: got %b want 00", haltCause); end
    if (retireCount !== 16'd0) begin errors++; $display("FAIL midrun_retire: got %0d want 0", retireCount); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_exec !== 1'b0) begin errors++; $display("FAIL midrun_idle_exec: got %b want 0", obs_exec); end
  endtask

  task automatic test_random();
    logic        rsm = 1'b0;
    logic        rst, st, sr, ab, je, be, iz;
    logic [31:0] ins;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op(0, 0), 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) rsm = ~rsm;
      sr  = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 39) == 0);
      ins = $urandom;
      ins[31:26] = ($urandom_range(0, 14) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      je  = ($urandom_range(0, 5) == 0);
      be  = ($urandom_range(0, 3) == 0);
      iz  = 1'($urandom_range(0, 1));
      drive(rst, st, rsm, sr, ab, ins, je, be, iz);
      checks += 6;
      if (obs_exec !== exp_exec) begin errors++; $display("FAIL rand_exec n%0d: got %b want %b", n, obs_exec, exp_exec); end
      if (pc !== m_pc[AW-1:0])   begin errors++; $display("FAIL rand_pc n%0d: got %0d want %0d", n, pc, m_pc); end
      if (running !== (m_state == M_RUN || m_state == M_STEP)) begin errors++; $display("FAIL rand_running n%0d: got %b state %0d", n, running, m_state); end
      if (halted !== (m_state == M_HALT)) begin errors++; $display("FAIL rand_halted n%0d: got %b state %0d", n, halted, m_state); end
      if (haltCause !== m_cause[1:0]) begin errors++; $display("FAIL rand_cause n%0d: got %0d want %0d", n, haltCause, m_cause); end
      if (retireCount !== 16'(exp_retire())) begin errors++; $display("FAIL rand_retire n%0d: got %0d want %0d", n, retireCount, exp_retire()); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stepMode = 1'b0; stepReq = 1'b0; abort = 1'b0;
    instruction = '0; jumpEnable = 1'b0; branchEnable = 1'b0; isZero = 1'b0;
    m_state = M_IDLE; m_pc = 0; m_cause = 0; m_cnt = 0;
    test_reset();
    test_free_run();
    test_branch_jump();
    test_step();
    test_out_of_range();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
